hazard_forward_ctrl: RTL and testbench

//  Hazard and forwarding controller for the 5-stage pipelined CPU.
//  - Tracks destination-register info of in-flight instructions in internal EX and MEM shadow slots.
//  - Drives the sel1/sel2 pairs of the two EX-operand 3:1 muxes and the PC-source 2:1 mux select.
//  - Generates load-use stall, bubble-insert and branch-flush controls for the IF/ID and ID/EX registers.

---
 rtl/hazard_forward_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_ctrl.sv
// Hazard detection and operand-forwarding control for the 5-stage pipeline.
// Optional cycle counters for stalls and flushes are enabled by defining HAZ_PERF_CNT_EN.
module hazard_forward_ctrl #(
   parameter int REG_AW   = 6,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              ex_branch_tkn,
   output logic              fwd_a_sel1,
   output logic              fwd_a_sel2,
   output logic              fwd_b_sel1,
   output logic              fwd_b_sel2,
   output logic              pc_sel,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              idex_bubble,
   output logic              ifid_flush
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [15:0]       stall_cnt,
   output logic [15:0]       flush_cnt
`endif
);

   localparam logic [1:0] SEL_RF  = 2'b00;
   localparam logic [1:0] SEL_EX  = 2'b01;
   localparam logic [1:0] SEL_MEM = 2'b10;

   // Shadow copies of the destination info held by the ID/EX and EX/MEM registers.
   logic              ex_valid;
   logic [REG_AW-1:0] ex_rd;
   logic              ex_rw;
   logic              ex_mr;
   logic              mem_valid;
   logic [REG_AW-1:0] mem_rd;
   logic              mem_rw;

   logic [1:0]        fwd_a_q;
   logic [1:0]        fwd_b_q;
   logic [1:0]        fwd_a_nxt;
   logic [1:0]        fwd_b_nxt;

   logic              ex_hit_a;
   logic              ex_hit_b;
   logic              mem_hit_a;
   logic              mem_hit_b;
   logic              stall;
   logic              flush;
   logic              bubble;

   function automatic logic slot_match(input logic              valid,
                                       input logic              reg_write,
                                       input logic [REG_AW-1:0] rd,
                                       input logic [REG_AW-1:0] rs);
      logic zero_src;
      zero_src = (ZERO_REG != 0) && (rs == '0);
      return valid && reg_write && (rd == rs) && !zero_src;
   endfunction

   assign ex_hit_a  = slot_match(ex_valid,  ex_rw,  ex_rd,  id_rs1);
   assign ex_hit_b  = slot_match(ex_valid,  ex_rw,  ex_rd,  id_rs2);
   assign mem_hit_a = slot_match(mem_valid, mem_rw, mem_rd, id_rs1);
   assign mem_hit_b = slot_match(mem_valid, mem_rw, mem_rd, id_rs2);

   // A taken branch squashes the ID instruction, so its load-use hazard is moot.
   assign flush  = ex_branch_tkn;
   assign stall  = id_valid && !ex_branch_tkn && (ex_hit_a || ex_hit_b) && ex_mr;
   assign bubble = stall || flush;

   // Youngest producer wins; a load in EX cannot forward yet (handled by the stall).
   always_comb begin
      fwd_a_nxt = SEL_RF;
      if (ex_hit_a && !ex_mr) begin
         fwd_a_nxt = SEL_EX;
      end else if (mem_hit_a) begin
         fwd_a_nxt = SEL_MEM;
      end
   end

   always_comb begin
      fwd_b_nxt = SEL_RF;
      if (ex_hit_b && !ex_mr) begin
         fwd_b_nxt = SEL_EX;
      end else if (mem_hit_b) begin
         fwd_b_nxt = SEL_MEM;
      end
   end

   always_comb begin
      pc_sel      = 1'b0;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_bubble = 1'b1;
      ifid_flush  = 1'b1;
      if (!rst) begin
         pc_sel      = flush;
         pc_write    = !stall;
         ifid_write  = !stall;
         idex_bubble = bubble;
         ifid_flush  = flush;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid  <= 1'b0;
         ex_rd     <= '0;
         ex_rw     <= 1'b0;
         ex_mr     <= 1'b0;
         mem_valid <= 1'b0;
         mem_rd    <= '0;
         mem_rw    <= 1'b0;
      end else begin
         ex_valid  <= id_valid && !bubble;
         ex_rd     <= id_rd;
         ex_rw     <= id_reg_write;
         ex_mr     <= id_mem_read;
         mem_valid <= ex_valid;
         mem_rd    <= ex_rd;
         mem_rw    <= ex_rw;
      end
   end

   // Selects travel with the instruction into EX; a bubble carries no operands.
   always_ff @(posedge clk) begin
      if (rst || bubble) begin
         fwd_a_q <= SEL_RF;
         fwd_b_q <= SEL_RF;
      end else begin
         fwd_a_q <= fwd_a_nxt;
         fwd_b_q <= fwd_b_nxt;
      end
   end

   assign fwd_a_sel1 = fwd_a_q[1];
   assign fwd_a_sel2 = fwd_a_q[0];
   assign fwd_b_sel1 = fwd_b_q[1];
   assign fwd_b_sel2 = fwd_b_q[0];

`ifdef HAZ_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
         if (flush && (flush_cnt != 16'hFFFF)) begin
            flush_cnt <= flush_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: table of per-cycle ID/branch vectors with expected
// combinational controls, plus a queue of expected forward selects checked one cycle later.
module tb_hazard_forward_ctrl;

   localparam int AW = 6;

   // Packed as {pc_sel, pc_write, ifid_write, idex_bubble, ifid_flush}.
   localparam logic [4:0] C_NORM  = 5'b01100;
   localparam logic [4:0] C_STALL = 5'b00010;
   localparam logic [4:0] C_FLUSH = 5'b11111;
   localparam logic [4:0] C_RST   = 5'b01111;
   localparam int NV = 28;

   logic          clk = 1'b0;
   logic          rst;
   logic          id_valid;
   logic [AW-1:0] id_rs1;
   logic [AW-1:0] id_rs2;
   logic [AW-1:0] id_rd;
   logic          id_reg_write;
   logic          id_mem_read;
   logic          ex_branch_tkn;
   logic          fwd_a_sel1;
   logic          fwd_a_sel2;
   logic          fwd_b_sel1;
   logic          fwd_b_sel2;
   logic          pc_sel;
   logic          pc_write;
   logic          ifid_write;
   logic          idex_bubble;
   logic          ifid_flush;
`ifdef HAZ_PERF_CNT_EN
   logic [15:0]   stall_cnt;
   logic [15:0]   flush_cnt;
`endif

   hazard_forward_ctrl #(.REG_AW(AW), .ZERO_REG(1)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .ex_branch_tkn(ex_branch_tkn),
      .fwd_a_sel1(fwd_a_sel1), .fwd_a_sel2(fwd_a_sel2),
      .fwd_b_sel1(fwd_b_sel1), .fwd_b_sel2(fwd_b_sel2),
      .pc_sel(pc_sel), .pc_write(pc_write), .ifid_write(ifid_write),
      .idex_bubble(idex_bubble), .ifid_flush(ifid_flush)
`ifdef HAZ_PERF_CNT_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          v;
      logic [AW-1:0] rs1;
      logic [AW-1:0] rs2;
      logic [AW-1:0] rd;
      logic          rw;
      logic          mr;
      logic          br;
      logic [4:0]    comb;
      logic [1:0]    fa;
      logic [1:0]    fb;
   } vec_t;

   vec_t       vt [NV];
   logic [3:0] exp_q [$];
   int         n_vec = 0;
   int         n_mis = 0;

   function automatic vec_t mk(input logic v, input int rs1, input int rs2, input int rd,
                               input logic rw, input logic mr, input logic br,
                               input logic [4:0] comb, input logic [1:0] fa,
                               input logic [1:0] fb);
      vec_t r;
      r.v = v; r.rs1 = AW'(rs1); r.rs2 = AW'(rs2); r.rd = AW'(rd);
      r.rw = rw; r.mr = mr; r.br = br; r.comb = comb; r.fa = fa; r.fb = fb;
      return r;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] comb_now();
      return {3'b000, pc_sel, pc_write, ifid_write, idex_bubble, ifid_flush};
   endfunction

   function automatic logic [7:0] fwd_now();
      return {4'h0, fwd_a_sel1, fwd_a_sel2, fwd_b_sel1, fwd_b_sel2};
   endfunction

   task automatic drive(input logic v, input int rs1, input int rs2, input int rd,
                        input logic rw, input logic mr, input logic br);
      id_valid = v; id_rs1 = AW'(rs1); id_rs2 = AW'(rs2); id_rd = AW'(rd);
      id_reg_write = rw; id_mem_read = mr; ex_branch_tkn = br;
   endtask

   // Forward selects registered at the previous posedge are visible at this negedge.
   task automatic pop_fwd(input string name);
      logic [3:0] e;
      if (exp_q.size() == 0) begin
         n_vec++; n_mis++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         e = exp_q.pop_front();
         chk(name, fwd_now(), {4'h0, e});
      end
   endtask

   initial begin
      vt[0]  = mk(0,  0,  0,  0, 0, 0, 0, C_NORM,  2'b00, 2'b00);
      vt[1]  = mk(1,  1,  2,  5, 1, 0, 0, C_NORM,  2'b00, 2'b00); // ADD r5
      vt[2]  = mk(1,  5,  6,  7, 1, 0, 0, C_NORM,  2'b01, 2'b00); // SUB r7,r5,r6
      vt[3]  = mk(0,  0,  0,  0, 0, 0, 0, C_NORM,  2'b00, 2'b00);
      vt[4]  = mk(1,  1,  2,  5, 1, 0, 0, C_NORM,  2'b00, 2'b00); // ADD r5
      vt[5]  = mk(0,  0,  0,  0, 0, 0, 0, C_NORM,  2'b00, 2'b00); // NOP
      vt[6]  = mk(1,  6,  5,  7, 1, 0, 0, C_NORM,  2'b00, 2'b10); // SUB r7,r6,r5
      vt[7]  = mk(1,  1,  2,  5, 1, 0, 0, C_NORM,  2'b00, 2'b00); // ADD r5
      vt[8]  = mk(1,  3,  4,  5, 1, 0, 0, C_NORM,  2'b00, 2'b00); // ADD r5 again
      vt[9]  = mk(1,  5,  9,  8, 1, 0, 0, C_NORM,  2'b01, 2'b00); // youngest wins
      vt[10] = mk(1,  1,  0,  3, 1, 1, 0, C_NORM,  2'b00, 2'b00); // LD r3
      vt[11] = mk(1,  3,  3,  4, 1, 0, 0, C_STALL, 2'b00, 2'b00); // ADD r4,r3,r3 stalls
      vt[12] = mk(1,  3,  3,  4, 1, 0, 0, C_NORM,  2'b10, 2'b10); // reissued
      vt[13] = mk(1,  1,  2,  0, 1, 0, 0, C_NORM,  2'b00, 2'b00); // writes r0
      vt[14] = mk(1,  0,  0,  9, 1, 0, 0, C_NORM,  2'b00, 2'b00); // reads r0
      vt[15] = mk(1,  2,  2,  0, 1, 1, 0, C_NORM,  2'b00, 2'b00); // LD r0
      vt[16] = mk(1,  0,  0, 10, 1, 0, 0, C_NORM,  2'b00, 2'b00); // no stall on r0
      vt[17] = mk(1,  1,  2,  3, 1, 1, 0, C_NORM,  2'b00, 2'b00); // LD r3
      vt[18] = mk(1,  3,  3,  4, 1, 0, 1, C_FLUSH, 2'b00, 2'b00); // branch beats stall
      vt[19] = mk(0,  0,  0,  0, 0, 0, 0, C_NORM,  2'b00, 2'b00);
      vt[20] = mk(1,  1,  2,  6, 0, 0, 0, C_NORM,  2'b00, 2'b00); // no reg write
      vt[21] = mk(1,  6,  6, 11, 1, 0, 0, C_NORM,  2'b00, 2'b00);
      vt[22] = mk(1, 11,  6, 12, 1, 0, 0, C_NORM,  2'b01, 2'b00);
      vt[23] = mk(1, 11, 12, 13, 1, 0, 0, C_NORM,  2'b10, 2'b01); // split sources
      vt[24] = mk(1,  1,  2, 14, 1, 0, 1, C_FLUSH, 2'b00, 2'b00); // plain branch
      vt[25] = mk(1, 13, 14, 15, 1, 0, 0, C_NORM,  2'b10, 2'b00);
      vt[26] = mk(1,  1,  2, 20, 1, 1, 0, C_NORM,  2'b00, 2'b00); // LD r20
      vt[27] = mk(0, 20,  0,  0, 0, 0, 0, C_NORM,  2'b00, 2'b00); // invalid ID, no stall

      // Reset held for two cycles.
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("rst_comb_c1", comb_now(), {3'b000, C_RST});
      @(negedge clk);
      chk("rst_comb_c2", comb_now(), {3'b000, C_RST});
      chk("rst_fwd", fwd_now(), 8'h00);
`ifdef HAZ_PERF_CNT_EN
      chk("rst_stall_cnt", stall_cnt[7:0], 8'h00);
      chk("rst_flush_cnt", flush_cnt[7:0], 8'h00);
`endif
      rst = 1'b0;
      #1;
      chk("post_rst_idle", comb_now(), {3'b000, C_NORM});

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         if (i > 0) pop_fwd($sformatf("fwd_v%0d", i - 1));
         drive(vt[i].v, int'(vt[i].rs1), int'(vt[i].rs2), int'(vt[i].rd),
               vt[i].rw, vt[i].mr, vt[i].br);
         #1;
         chk($sformatf("comb_v%0d", i), comb_now(), {3'b000, vt[i].comb});
         exp_q.push_back({vt[i].fa, vt[i].fb});
      end
      @(negedge clk);
      pop_fwd($sformatf("fwd_v%0d", NV - 1));
`ifdef HAZ_PERF_CNT_EN
      chk("stall_cnt", stall_cnt[7:0], 8'd1);
      chk("flush_cnt", flush_cnt[7:0], 8'd2);
`endif

      // Reset asserted while a load-use stall is pending: no stall survives it.
      drive(1, 1, 2, 3, 1, 1, 0);
      @(negedge clk);
      drive(1, 3, 3, 4, 1, 0, 0);
      #1;
      chk("pre_rst_stall", comb_now(), {3'b000, C_STALL});
      rst = 1'b1;
      #1;
      chk("rst_mid_stall", comb_now(), {3'b000, C_RST});
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("no_residual_stall", comb_now(), {3'b000, C_NORM});
      chk("rst_mid_fwd", fwd_now(), 8'h00);
      exp_q.push_back(4'b0000);
      @(negedge clk);
      pop_fwd("fwd_after_rst");
`ifdef HAZ_PERF_CNT_EN
      chk("stall_cnt_after_rst", stall_cnt[7:0], 8'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
